fetch_stage: RTL

- F stage of the 5-stage MIPS pipeline with precise exceptions.
- Owns the PC register and computes the next PC: sequential, branch/jump target, exception entry, or eret return.
- Drives the instruction-memory address and produces the F-stage bundle consumed by the F/D pipeline register: instruction, PC, PC+8, delay-slot flag, fetch-AdEL flag.
- Keeps a wrapping fetch counter for debug.

---
 rtl/fetch_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: F stage of the 5-stage MIPS pipeline with precise exceptions.
//
// Owns the PC register. Each cycle it picks the next PC from the sequential
// PC, a resolved branch/jump target, the exception entry point or the CP0 EPC
// (eret). It also presents the F-stage bundle to the F/D pipeline register.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall           hazard stall, holds pc and fetch_count
//   req             exception/interrupt request, redirects to HANDLER_PC
//   eret, epc       eret in D, redirect to epc (no delay slot)
//   d_is_jump       instruction in D is a branch/jump (F holds its delay slot)
//   d_taken         branch/jump in D resolved taken
//   d_target        resolved branch/jump target
//   i_inst_rdata    instruction-memory read data (combinational in address)
//   i_inst_addr     instruction-memory address (= pc)
//   f_instr         fetched instruction (nop when the fetch address is bad)
//   f_pc, f_pc_8    PC of the fetched instruction and PC + 8
//   f_bd            fetched instruction is in a delay slot
//   f_adel          fetch address error
//   fetch_count     wrapping count of PC advances since reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        d_is_jump,
    input  logic        d_taken,
    input  logic [31:0] d_target,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc_8,
    output logic        f_bd,
    output logic        f_adel,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] count;

    // req outranks stall so an interrupt is never lost behind a hazard.
    // eret outranks a taken branch: the two cannot legally coincide, and
    // eret must not execute a delay slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            count <= 32'd0;
        end else if (req) begin
            pc    <= HANDLER_PC;
            count <= count + 32'd1;
        end else if (!stall) begin
            if (eret) begin
                pc <= epc;
            end else if (d_is_jump && d_taken) begin
                pc <= d_target;
            end else begin
                pc <= pc + 32'd4;
            end
            count <= count + 32'd1;
        end
    end

    // epc and d_target are not checked when taken; a bad address is caught
    // here once it becomes the fetch PC.
    assign f_adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

    // Memory still sees the bad address; its data is replaced by a nop.
    assign i_inst_addr = pc;
    assign f_instr     = f_adel ? 32'd0 : i_inst_rdata;
    assign f_pc        = pc;
    assign f_pc_8      = pc + 32'd8;
    assign f_bd        = d_is_jump;
    assign fetch_count = count;

endmodule
